// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU-side datapath blocks.
// Covers the multiply/divide unit operation codes and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  // Callers zero-extend into this width and size-cast the result back down.
  // Any vector up to MDU_MAX_W bits can be negated, which limits WIDTH to 64.
  localparam int unsigned MDU_MAX_W = 128;

  function automatic logic [MDU_MAX_W-1:0] twos_neg(input logic [MDU_MAX_W-1:0] v);
    return ~v + MDU_MAX_W'(1);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Single combinational iteration of the MDU.
// Performs either a shift-add multiply step or a restoring divide step on a shared 2*WIDTH accumulator.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_ok;

  // Multiply: the upper half accumulates partial products and the lower half holds the
  // unconsumed multiplier bits. Divide: the upper half is the remainder and the lower
  // half is the dividend being shifted out while quotient bits are shifted in.
  always_comb begin
    add_sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    shifted_rem = acc_in[2*WIDTH-1:WIDTH-1];
    sub_ok      = (shifted_rem >= {1'b0, operand});
    sub_diff    = shifted_rem[WIDTH-1:0] - operand;
    acc_out     = {add_sum, acc_in[WIDTH-1:1]};
    if (is_div) begin
      if (sub_ok) begin
        acc_out = {sub_diff, acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {shifted_rem[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then applies sign fixes in a single FIX cycle.
module mdu_hilo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             is_arith, is_signed, is_div_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [DW-1:0]    acc_next;
  logic [DW-1:0]    prod_neg;
  logic [WIDTH-1:0] quot_neg, rem_negv;

  mdu_iter_core #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .operand (opnd_q),
    .acc_out (acc_next)
  );

  always_comb begin
    is_arith  = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? WIDTH'(twos_neg(MDU_MAX_W'(a))) : a;
    b_mag     = b_neg ? WIDTH'(twos_neg(MDU_MAX_W'(b))) : b;
    prod_neg  = DW'(twos_neg(MDU_MAX_W'(acc_q)));
    quot_neg  = WIDTH'(twos_neg(MDU_MAX_W'(acc_q[WIDTH-1:0])));
    rem_negv  = WIDTH'(twos_neg(MDU_MAX_W'(acc_q[DW-1:WIDTH])));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    b_zero_d   = b_zero_q;
    a_raw_d    = a_raw_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_arith) begin
            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
            acc_d     = is_div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_d    = is_div_op ? b_mag : a_mag;
            is_div_d  = is_div_op;
            res_neg_d = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            b_zero_d  = (b == '0);
            a_raw_d   = a;
            cnt_d     = CW'(WIDTH);
            state_d   = CALC;
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end

      CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (is_div_q) begin
          if (b_zero_q) begin
            lo_d       = '1;
            hi_d       = a_raw_q;
            div_zero_d = 1'b1;
          end else begin
            // The most-negative / -1 case yields a magnitude quotient of 2^(W-1) with no
            // negation applied, which is exactly the required wrapped result.
            lo_d = res_neg_q ? quot_neg : acc_q[WIDTH-1:0];
            hi_d = rem_neg_q ? rem_negv : acc_q[DW-1:WIDTH];
          end
        end else begin
          {hi_d, lo_d} = res_neg_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      a_raw_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      b_zero_q   <= b_zero_d;
      a_raw_q    <= a_raw_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
